// File: rtl/seq_step_ctrl.sv
// seq_step_ctrl
// Programmable sequence controller. A small writable table of 4-bit state
// codes is stepped through on each tick while running; the current code is
// driven on count for downstream display/decode logic.
//
// Optional feature macro: SEQ_CTRL_LOOP_EN
//   defined   : loop target (loops), done pulse and DONE state present
//   undefined : loops ignored, runs continue until stop, done tied 0
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   cfg_we/addr/data  table write port (accepted only while idle)
//   len               number of valid entries, sampled on accepted start
//   loops             loop target (0 = forever), sampled on accepted start
//   start, stop, tick run control and advance strobe
//   count             current state code (registered)
//   busy              high while running
//   done              one-cycle pulse when the loop target is reached
//   err               one-cycle pulse on a rejected command
//   loop_cnt          completed passes in the current run (saturating)
module seq_step_ctrl #(
  parameter int DEPTH = 8,
  parameter int AW    = 3,
  parameter int LW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cfg_we,
  input  logic [AW-1:0] cfg_addr,
  input  logic [3:0]    cfg_data,
  input  logic [AW:0]   len,
  input  logic [LW-1:0] loops,
  input  logic          start,
  input  logic          stop,
  input  logic          tick,
  output logic [3:0]    count,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [LW-1:0] loop_cnt
);

`ifdef SEQ_CTRL_LOOP_EN
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_RUN} state_t;
`endif

  state_t        state, state_nxt;
  logic [3:0]    tbl [DEPTH];
  logic          tbl_we;
  logic [AW-1:0] idx, idx_nxt;
  logic [AW:0]   len_q, len_nxt;
  logic [3:0]    count_nxt;
  logic          err_nxt;
  logic [LW-1:0] loop_nxt;
  logic [LW-1:0] loop_inc;
  logic          len_ok;
  logic          wrap;
  logic [3:0]    first_code;

`ifdef SEQ_CTRL_LOOP_EN
  logic [LW-1:0] loops_q, loops_nxt;
`else
  logic          unused_loops;
  assign unused_loops = ^loops;
`endif

  function automatic logic [3:0] default_entry(input int i);
    case (i)
      1:       default_entry = 4'b1000;
      2:       default_entry = 4'b0101;
      3:       default_entry = 4'b1101;
      4:       default_entry = 4'b0111;
      default: default_entry = 4'b0000;
    endcase
  endfunction

  assign len_ok   = (len != '0) && (len <= (AW+1)'(DEPTH));
  assign wrap     = ({1'b0, idx} == (len_q - (AW+1)'(1)));
  assign loop_inc = (loop_cnt == '1) ? loop_cnt : loop_cnt + LW'(1);
  // A write to entry 0 in the same cycle as start is seen immediately.
  assign first_code = (cfg_we && (cfg_addr == '0)) ? cfg_data : tbl[0];

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    len_nxt   = len_q;
    count_nxt = count;
    err_nxt   = 1'b0;
    loop_nxt  = loop_cnt;
    tbl_we    = 1'b0;
`ifdef SEQ_CTRL_LOOP_EN
    loops_nxt = loops_q;
`endif
    case (state)
      S_IDLE: begin
        tbl_we = cfg_we;
        if (start) begin
          if (len_ok) begin
            len_nxt   = len;
`ifdef SEQ_CTRL_LOOP_EN
            loops_nxt = loops;
`endif
            idx_nxt   = '0;
            count_nxt = first_code;
            loop_nxt  = '0;
            state_nxt = S_RUN;
          end else begin
            err_nxt = 1'b1;
          end
        end
      end
      S_RUN: begin
        err_nxt = cfg_we;
        if (stop) begin
          state_nxt = S_IDLE;
          count_nxt = 4'b0000;
          idx_nxt   = '0;
        end else if (tick) begin
          if (wrap) begin
            idx_nxt   = '0;
            count_nxt = tbl[0];
            loop_nxt  = loop_inc;
`ifdef SEQ_CTRL_LOOP_EN
            if ((loops_q != '0) && (loop_inc == loops_q))
              state_nxt = S_DONE;
`endif
          end else begin
            idx_nxt   = idx + AW'(1);
            count_nxt = tbl[idx + AW'(1)];
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      idx      <= '0;
      len_q    <= (AW+1)'(5);
      count    <= 4'b0000;
      err      <= 1'b0;
      loop_cnt <= '0;
`ifdef SEQ_CTRL_LOOP_EN
      loops_q  <= '0;
`endif
    end else begin
      state    <= state_nxt;
      idx      <= idx_nxt;
      len_q    <= len_nxt;
      count    <= count_nxt;
      err      <= err_nxt;
      loop_cnt <= loop_nxt;
`ifdef SEQ_CTRL_LOOP_EN
      loops_q  <= loops_nxt;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++)
        tbl[i] <= default_entry(i);
    end else if (tbl_we) begin
      tbl[cfg_addr] <= cfg_data;
    end
  end

  assign busy = (state == S_RUN);
`ifdef SEQ_CTRL_LOOP_EN
  assign done = (state == S_DONE);
`else
  assign done = 1'b0;
`endif

endmodule

// File: tb/tb_seq_step_ctrl.sv
// Directed testbench for seq_step_ctrl (default DEPTH=8, AW=3, LW=8).
module tb_seq_step_ctrl;

  logic       clk = 1'b0;
  logic       rst, cfg_we, start, stop, tick;
  logic [2:0] cfg_addr;
  logic [3:0] cfg_data;
  logic [3:0] len;
  logic [7:0] loops;
  logic [3:0] count;
  logic       busy, done, err;
  logic [7:0] loop_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  seq_step_ctrl #(.DEPTH(8), .AW(3), .LW(8)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .len(len), .loops(loops), .start(start),
    .stop(stop), .tick(tick), .count(count), .busy(busy), .done(done),
    .err(err), .loop_cnt(loop_cnt)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cfg_we = 0; cfg_addr = 0; cfg_data = 0;
    start = 0; stop = 0; tick = 0;
  endtask

  task automatic do_tick(input string tag, input logic [3:0] exp_count);
    tick = 1;
    step();
    tick = 0;
    check(tag, count, exp_count);
  endtask

  task automatic write_entry(input logic [2:0] a, input logic [3:0] d);
    cfg_we = 1; cfg_addr = a; cfg_data = d;
    step();
    cfg_we = 0;
  endtask

  task automatic run_default_seq();
    logic [3:0] exp_seq [6];
    exp_seq = '{4'h8, 4'h5, 4'hD, 4'h7, 4'h0, 4'h8};
    len = 5; loops = 0; start = 1;
    step();
    start = 0;
    check("def_start_busy", busy, 1);
    check("def_start_count", count, 4'h0);
    for (int i = 0; i < 6; i++) begin
      do_tick("def_step", exp_seq[i]);
      if (i == 4) check("def_loop_after5", loop_cnt, 1);
    end
    stop = 1;
    step();
    stop = 0;
    check("def_stop_busy", busy, 0);
    check("def_stop_count", count, 4'h0);
    check("def_stop_loopcnt_held", loop_cnt, 1);
  endtask

  initial begin
    idle_inputs();
    len = 5; loops = 0;
    rst = 1;
    step(); step();
    rst = 0;
    check("rst_count", count, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_loopcnt", loop_cnt, 0);

    // Default table walk
    run_default_seq();

    // Programmed table {3,9,F}, len 3, loops 2
    write_entry(0, 4'h3);
    write_entry(1, 4'h9);
    write_entry(2, 4'hF);
    len = 3; loops = 2; start = 1;
    step();
    start = 0;
    check("prog_start_count", count, 4'h3);
    do_tick("prog_t1", 4'h9);
    do_tick("prog_t2", 4'hF);
    do_tick("prog_t3", 4'h3);
    do_tick("prog_t4", 4'h9);
    do_tick("prog_t5", 4'hF);
    do_tick("prog_t6", 4'h3);
    check("prog_loopcnt", loop_cnt, 2);
`ifdef SEQ_CTRL_LOOP_EN
    check("prog_done_pulse", done, 1);
    check("prog_done_busy", busy, 0);
    tick = 1;  // ignored in DONE
    step();
    tick = 0;
    check("prog_done_clear", done, 0);
    check("prog_after_busy", busy, 0);
    check("prog_after_count", count, 4'h3);
    check("prog_after_loopcnt", loop_cnt, 2);
`else
    check("prog_nodone", done, 0);
    check("prog_still_busy", busy, 1);
    stop = 1;
    step();
    stop = 0;
    check("prog_stop_busy", busy, 0);
`endif

    // Write-through: start and write to entry 0 in the same cycle
    cfg_we = 1; cfg_addr = 0; cfg_data = 4'h6;
    len = 3; loops = 0; start = 1;
    step();
    cfg_we = 0; start = 0;
    check("wt_count", count, 4'h6);
    check("wt_busy", busy, 1);
    // start while running is ignored without err
    start = 1;
    do_tick("run_start_ignored_count", 4'h9);
    start = 0;
    check("run_start_no_err", err, 0);
    do_tick("mid_idx2", 4'hF);
    // stop and tick together at index 2: stop wins
    stop = 1; tick = 1;
    step();
    stop = 0; tick = 0;
    check("stoptick_busy", busy, 0);
    check("stoptick_count", count, 4'h0);

    // Illegal len values
    len = 0; start = 1;
    step();
    start = 0;
    check("len0_err", err, 1);
    check("len0_busy", busy, 0);
    check("len0_count", count, 4'h0);
    step();
    check("len0_err_clear", err, 0);
    len = 9; start = 1;
    step();
    start = 0;
    check("len9_err", err, 1);
    check("len9_busy", busy, 0);
    step();
    check("len9_err_clear", err, 0);

    // cfg_we while running is dropped and flagged
    len = 3; loops = 0; start = 1;
    step();
    start = 0;
    write_entry(1, 4'hA);
    check("runwr_err", err, 1);
    check("runwr_count", count, 4'h6);
    step();
    check("runwr_err_clear", err, 0);
    do_tick("runwr_readback", 4'h9);
    stop = 1;
    step();
    stop = 0;

    // len = 1: every tick is a full pass
    len = 1; loops = 0; start = 1;
    step();
    start = 0;
    for (int i = 1; i <= 3; i++) begin
      do_tick("len1_count", 4'h6);
      check("len1_loopcnt", loop_cnt, i);
    end
    // run on to saturation
    tick = 1;
    for (int i = 0; i < 257; i++) step();
    tick = 0;
    check("sat_loopcnt", loop_cnt, 8'hFF);
    check("sat_busy", busy, 1);
    stop = 1;
    step();
    stop = 0;

    // Reset mid-run restores the default table
    len = 3; loops = 0; start = 1;
    step();
    start = 0;
    do_tick("pre_rst_t1", 4'h9);
    do_tick("pre_rst_t2", 4'hF);
    do_tick("pre_rst_t3", 4'h6);
    check("pre_rst_loopcnt", loop_cnt, 1);
    rst = 1; tick = 1;
    step();
    rst = 0; tick = 0;
    check("midrst_count", count, 0);
    check("midrst_busy", busy, 0);
    check("midrst_loopcnt", loop_cnt, 0);
    run_default_seq();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_step_ctrl.md
# seq_step_ctrl

Programmable sequence controller for the team's arbitrary-sequence counters. It holds a small writable table of 4-bit state codes and steps through it on an advance strobe. It supports start/stop control, loop counting and completion signalling. It replaces hard-wired next-state case logic with a configurable sequencer that drives `count` to downstream display and decode logic.

## Interface
- `DEPTH`, default 8: number of table entries. Must be a power of two, 2..16.
- `AW`, default 3: table address width, equal to log2(DEPTH).
- `LW`, default 8: width of the loop counter and loop target.
- `clk`  in  1: clock. All logic is rising-edge.
- `rst`  in  1: reset, synchronous, active-high.
- `cfg_we`  in  1: write table entry. Honoured only in IDLE.
- `cfg_addr`  in  AW: table write address.
- `cfg_data`  in  4: table write data (state code).
- `len`  in  AW+1: number of valid entries, 1..DEPTH. Sampled on accepted `start`.
- `loops`  in  LW: loop target. 0 means run forever. Sampled on accepted `start`.
- `start`  in  1: begin sequencing. Level-sampled.
- `stop`  in  1: abort sequencing.
- `tick`  in  1: advance strobe, one step per high cycle.
- `count`  out  4: current state code (registered).
- `busy`  out  1: high in RUN.
- `done`  out  1: one-cycle pulse on loop target reached.
- `err`  out  1: one-cycle pulse on rejected command.
- `loop_cnt`  out  LW: completed passes in the current run.

## Operation
- State machine: IDLE, RUN, DONE.
- Reset values: state IDLE, `count`=0, `busy`=0, `done`=0, `err`=0, `loop_cnt`=0, index=0.
- Reset table contents:
  - entries 0..4 = 0000, 1000, 0101, 1101, 0111
  - remaining entries = 0000
  - reset `len` shadow = 5
- IDLE:
  - `cfg_we` writes `table[cfg_addr]`=`cfg_data` at the clock edge.
  - `start` with `len` in 1..DEPTH: latch `len` and `loops`, index=0, `count`=`table[0]`, `loop_cnt`=0, go to RUN.
  - `start` with `len`=0 or `len`>DEPTH: pulse `err`, stay IDLE, outputs unchanged.
  - `start` and `cfg_we` in the same cycle: the write lands first and `count` takes the new `table[0]` if addr=0 (write-through).
- RUN, on `tick`:
  - If index < len-1: index+1, `count`=`table[index+1]`.
  - If index = len-1: index=0, `count`=`table[0]`, `loop_cnt`+1.
  - If the new `loop_cnt` equals `loops` (≠0): go to DONE.
- RUN, other commands:
  - `stop` in RUN: go to IDLE, `count`=0, index=0. `loop_cnt` is held.
  - `stop` and `tick` in the same cycle: `stop` wins, no advance.
  - `start` in RUN: ignored, no `err`.
  - `cfg_we` in RUN: write dropped, `err` pulses.
- DONE lasts exactly one cycle:
  - `done`=1, `busy`=0, `count` holds `table[0]`, `loop_cnt` holds its final value.
  - Next cycle is IDLE. `tick`, `stop` and `start` are ignored in DONE.
- `loop_cnt` saturates at 2^LW−1 when `loops`=0. It never wraps to 0.
- `len`=1: every `tick` is a full pass. `count` stays `table[0]` and `loop_cnt` increments.

## Timing
- `count` updates on the edge where `tick` is sampled high, so it is visible the next cycle (1-cycle latency).
- From `start` accepted to `count`=`table[0]` and `busy`=1: 1 cycle.
- From the terminal `tick` to `done`=1: 1 cycle, with `busy` low in the same cycle.
- `err` and `done` are registered single-cycle pulses.
- `rst` mid-run takes effect at the next edge and overrides all inputs. The table returns to its default contents.
- Back-to-back ticks are supported, giving one step per cycle.

## Configuration
- `SEQ_CTRL_LOOP_EN` defined:
  - loop target logic, `done` and DONE state present as described above.
- `SEQ_CTRL_LOOP_EN` undefined:
  - `loops` input is ignored and runs continue until `stop`.
  - DONE state is removed and `done` is tied 0.
  - `loop_cnt` still counts completed passes, saturating.

## Test plan
- Default table after `rst`: `len` shadow=5, `start` with `len`=5, `loops`=0, 6 ticks → `count` 0000,1000,0101,1101,0111,0000,1000. `loop_cnt`=1 after the 5th tick.
- Write table {3,9,F} with `len`=3, `loops`=2, then 6 ticks → `count` 9,F,3,9,F,3. `done` pulses once the cycle after the 6th tick, then `busy`=0 and `count`=3.
- Mid-run `stop` and `tick` in the same cycle at index 2 → no advance, next cycle `busy`=0, `count`=0.
- `start` with `len`=0, and separately with `len`=DEPTH+1 → `err` pulses 1 cycle, state stays IDLE, `count` unchanged.
- `cfg_we` during RUN to addr 1 with data 0xA → `err` pulses, a later readback via stepping still shows the old entry.
- `rst` asserted after 3 ticks → next cycle `count`=0, `busy`=0, `loop_cnt`=0, and the table is restored to default (verified by re-running the first scenario).
